// File: rtl/valid_array_sa.sv
// Valid-bit store for the set-associative cache: same-cycle lookup, per-set victim
// selection (first invalid way, else round-robin) and a one-set-per-cycle flush sequencer.
module valid_array_sa #(
    parameter int SETS  = 8,
    parameter int WAYS  = 4,
    parameter int IDX_W = 3,
    parameter int WAY_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_index,
    output logic [WAYS-1:0]  valid_out,
    output logic [WAY_W-1:0] victim_way,
    output logic             set_full,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [WAY_W-1:0] fill_way,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_index,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done
);

    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

    state_t                     state, state_next;
    logic [SETS-1:0][WAYS-1:0]  valid;
    logic [SETS-1:0][WAY_W-1:0] rr;
    logic [IDX_W-1:0]           cnt;
    logic [WAYS-1:0]            rd_bits;
    logic                       found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        flush_busy = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE:  if (flush_req) state_next = FLUSH;
            FLUSH: begin
                flush_busy = 1'b1;
                if (cnt == IDX_W'(SETS - 1)) state_next = DONE;
            end
            DONE: begin
                flush_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Invalidate is written after fill so it wins on a same-entry collision;
    // the rr advance still looks at the pre-edge fullness of the fill set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            rr    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        cnt <= '0;
                    end else begin
                        if (fill_en) begin
                            valid[fill_index][fill_way] <= 1'b1;
                            if (&valid[fill_index])
                                rr[fill_index] <= rr[fill_index] + WAY_W'(1);
                        end
                        if (inv_en)
                            valid[inv_index][inv_way] <= 1'b0;
                    end
                end
                FLUSH: begin
                    valid[cnt] <= '0;
                    rr[cnt]    <= '0;
                    cnt        <= cnt + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_bits    = valid[rd_index];
        valid_out  = '0;
        set_full   = 1'b0;
        victim_way = '0;
        found      = 1'b0;
        if (state != FLUSH) begin
            valid_out = rd_bits;
            set_full  = &rd_bits;
            if (set_full) begin
                victim_way = rr[rd_index];
            end else begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (!found && !rd_bits[w]) begin
                        victim_way = WAY_W'(w);
                        found      = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_valid_array_sa.sv
// Directed bench for valid_array_sa: table of fill/invalidate vectors plus hand-written
// flush and reset-during-flush sequences.
module tb_valid_array_sa;

    logic       clk;
    logic       reset;
    logic [2:0] rd_index;
    logic [3:0] valid_out;
    logic [1:0] victim_way;
    logic       set_full;
    logic       fill_en;
    logic [2:0] fill_index;
    logic [1:0] fill_way;
    logic       inv_en;
    logic [2:0] inv_index;
    logic [1:0] inv_way;
    logic       flush_req;
    logic       flush_busy;
    logic       flush_done;

    int checks = 0;
    int errors = 0;

    valid_array_sa #(.SETS(8), .WAYS(4), .IDX_W(3), .WAY_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (rd_index),
        .valid_out  (valid_out),
        .victim_way (victim_way),
        .set_full   (set_full),
        .fill_en    (fill_en),
        .fill_index (fill_index),
        .fill_way   (fill_way),
        .inv_en     (inv_en),
        .inv_index  (inv_index),
        .inv_way    (inv_way),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] rd;
        logic       fe;
        logic [2:0] fi;
        logic [1:0] fw;
        logic       ie;
        logic [2:0] ii;
        logic [1:0] iw;
        logic [3:0] exp_valid;
        logic [1:0] exp_victim;
        logic       exp_full;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [2:0] rd, logic fe, logic [2:0] fi, logic [1:0] fw,
                                logic ie, logic [2:0] ii, logic [1:0] iw,
                                logic [3:0] ev, logic [1:0] evic, logic ef);
        vec_t v;
        v.rd = rd; v.fe = fe; v.fi = fi; v.fw = fw;
        v.ie = ie; v.ii = ii; v.iw = iw;
        v.exp_valid = ev; v.exp_victim = evic; v.exp_full = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_lookup(input string name, input logic [3:0] ev,
                              input logic [1:0] evic, input logic ef);
        chk({name, " valid_out"}, 32'(valid_out), 32'(ev));
        chk({name, " victim_way"}, 32'(victim_way), 32'(evic));
        chk({name, " set_full"}, 32'(set_full), 32'(ef));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            rd   fe fi   fw   ie ii   iw   valid    vic  full
        vecs[0]  = mk(3'd3, 1, 3'd3, 2'd0, 0, 3'd0, 2'd0, 4'b0001, 2'd1, 0);
        vecs[1]  = mk(3'd3, 1, 3'd3, 2'd1, 0, 3'd0, 2'd0, 4'b0011, 2'd2, 0);
        vecs[2]  = mk(3'd3, 1, 3'd3, 2'd2, 0, 3'd0, 2'd0, 4'b0111, 2'd3, 0);
        vecs[3]  = mk(3'd3, 1, 3'd3, 2'd3, 0, 3'd0, 2'd0, 4'b1111, 2'd0, 1);
        vecs[4]  = mk(3'd3, 1, 3'd3, 2'd0, 0, 3'd0, 2'd0, 4'b1111, 2'd1, 1);
        vecs[5]  = mk(3'd3, 1, 3'd3, 2'd1, 0, 3'd0, 2'd0, 4'b1111, 2'd2, 1);
        vecs[6]  = mk(3'd3, 0, 3'd0, 2'd0, 1, 3'd3, 2'd2, 4'b1011, 2'd2, 0);
        vecs[7]  = mk(3'd3, 1, 3'd3, 2'd2, 0, 3'd0, 2'd0, 4'b1111, 2'd2, 1);
        vecs[8]  = mk(3'd3, 1, 3'd3, 2'd0, 1, 3'd3, 2'd0, 4'b1110, 2'd0, 0);
        vecs[9]  = mk(3'd3, 1, 3'd3, 2'd0, 0, 3'd0, 2'd0, 4'b1111, 2'd3, 1);
        vecs[10] = mk(3'd5, 1, 3'd5, 2'd1, 1, 3'd5, 2'd1, 4'b0000, 2'd0, 0);
        vecs[11] = mk(3'd5, 1, 3'd5, 2'd1, 1, 3'd6, 2'd0, 4'b0010, 2'd0, 0);
        vecs[12] = mk(3'd6, 1, 3'd6, 2'd3, 0, 3'd0, 2'd0, 4'b1000, 2'd0, 0);
        vecs[13] = mk(3'd0, 1, 3'd0, 2'd1, 0, 3'd0, 2'd0, 4'b0010, 2'd0, 0);
        vecs[14] = mk(3'd0, 1, 3'd0, 2'd0, 0, 3'd0, 2'd0, 4'b0011, 2'd2, 0);
        vecs[15] = mk(3'd7, 1, 3'd7, 2'd2, 0, 3'd0, 2'd0, 4'b0100, 2'd0, 0);

        reset = 1'b0;
        rd_index = '0; fill_en = 1'b0; fill_index = '0; fill_way = '0;
        inv_en = 1'b0; inv_index = '0; inv_way = '0; flush_req = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset flush_busy", 32'(flush_busy), 32'd0);
        chk("reset flush_done", 32'(flush_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        for (int s = 0; s < 8; s++) begin
            rd_index = 3'(s);
            #1;
            chk_lookup($sformatf("reset set%0d", s), 4'b0000, 2'd0, 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            rd_index = vecs[i].rd;
            fill_en = vecs[i].fe; fill_index = vecs[i].fi; fill_way = vecs[i].fw;
            inv_en = vecs[i].ie; inv_index = vecs[i].ii; inv_way = vecs[i].iw;
            step();
            chk_lookup($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_victim,
                       vecs[i].exp_full);
            chk($sformatf("vec%0d flush_busy", i), 32'(flush_busy), 32'd0);
            fill_en = 1'b0;
            inv_en = 1'b0;
        end

        // Flush: a fill requested alongside flush_req and during FLUSH/DONE must be dropped.
        rd_index = 3'd3;
        flush_req = 1'b1;
        fill_en = 1'b1; fill_index = 3'd1; fill_way = 2'd0;
        step();
        flush_req = 1'b0;
        fill_way = 2'd1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("flush cyc%0d busy", i), 32'(flush_busy), 32'd1);
            chk($sformatf("flush cyc%0d done", i), 32'(flush_done), 32'd0);
            chk_lookup($sformatf("flush cyc%0d", i), 4'b0000, 2'd0, 1'b0);
            step();
        end
        chk("flush end busy", 32'(flush_busy), 32'd0);
        chk("flush end done", 32'(flush_done), 32'd1);
        fill_index = 3'd2; fill_way = 2'd0;
        step();
        fill_en = 1'b0;
        chk("after done pulse", 32'(flush_done), 32'd0);
        chk("after done busy", 32'(flush_busy), 32'd0);
        for (int s = 0; s < 8; s++) begin
            rd_index = 3'(s);
            #1;
            chk_lookup($sformatf("post flush set%0d", s), 4'b0000, 2'd0, 1'b0);
        end

        // rr of set 3 was 3 before the flush; full set must now point at way 0.
        rd_index = 3'd3;
        for (int w = 0; w < 4; w++) begin
            fill_en = 1'b1; fill_index = 3'd3; fill_way = 2'(w);
            step();
        end
        fill_en = 1'b0;
        chk_lookup("rr cleared", 4'b1111, 2'd0, 1'b1);
        fill_en = 1'b1; fill_way = 2'd0;
        step();
        fill_en = 1'b0;
        chk_lookup("rr advance after flush", 4'b1111, 2'd1, 1'b1);

        // Reset during the fourth FLUSH cycle.
        rd_index = 3'd4;
        fill_en = 1'b1; fill_index = 3'd4; fill_way = 2'd0;
        step();
        fill_en = 1'b0;
        chk_lookup("pre-abort fill", 4'b0001, 2'd1, 1'b0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (3) step();
        chk("abort busy before reset", 32'(flush_busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort busy immediate", 32'(flush_busy), 32'd0);
        chk("abort done immediate", 32'(flush_done), 32'd0);
        chk_lookup("abort set4 cleared", 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("abort hold%0d done", i), 32'(flush_done), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("abort release%0d done", i), 32'(flush_done), 32'd0);
            chk($sformatf("abort release%0d busy", i), 32'(flush_busy), 32'd0);
        end
        for (int s = 0; s < 8; s++) begin
            rd_index = 3'(s);
            #1;
            chk_lookup($sformatf("abort set%0d", s), 4'b0000, 2'd0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
